register_file_v3: RTL and testbench

Parametrised successor register file for the simple microprocessor datapath.
- Two synchronous read ports and one CPU write port, all usable in the same cycle; reads no longer stall behind writes.
- A switch-driven record port lets the board user load a register directly.
- A built-in clear engine walks the whole array writing a fill value, signalling busy while it runs and done when it finishes.

---
 rtl/rf_pkg.sv | 46 ++++
 rtl/rf_clear_engine.sv | 109 ++++++++++
 rtl/register_file_v3.sv | 143 ++++++++++++++
 tb/tb_register_file_v3.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared types, default parameters and the reset table for the
//               register_file_v3 register file and its clear engine.
//               Contents:
//                 rf_state_t      - clear engine state encoding
//                 C_DEF_*         - default parameter values
//                 rf_reset_value  - reset-table entry for a register index
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int C_DEF_DATA_W = 4;
    localparam int C_DEF_ADDR_W = 3;
    localparam int C_DEF_BYPASS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } rf_state_t;

    // Reset contents: reg0=6, reg1=3, every other register holds its own
    // index. All entries are reduced modulo 2**data_w so narrow
    // configurations still get a well-defined table.
    function automatic logic [31:0] rf_reset_value(input int index, input int data_w);
        logic [31:0] raw;
        logic [31:0] mask;
        if (index == 0) begin
            raw = 32'd6;
        end else if (index == 1) begin
            raw = 32'd3;
        end else begin
            raw = 32'(index);
        end
        if (data_w >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << data_w) - 32'd1;
        end
        return raw & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : rf_clear_engine
// Description : Walks the whole register array writing a latched fill value.
//               IDLE -> CLEAR (DEPTH cycles, one write per cycle) -> DONE
//               (one cycle, init_done pulse) -> IDLE.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               init_req       - start request, honoured only in IDLE
//               init_val       - fill value, captured with init_req
//               clr_en/addr/data - array write request for this cycle
//               busy           - high for the whole CLEAR phase
//               init_done      - one-cycle pulse when the fill completes
// Revision    : 1.0 - initial release
// ============================================================================
module rf_clear_engine
    import rf_pkg::*;
#(
    parameter int DATA_W = C_DEF_DATA_W,
    parameter int ADDR_W = C_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic [DATA_W-1:0] init_val,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data,
    output logic              busy,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_clear = CLEAR;
    localparam logic [1:0] c_st_done  = DONE;

    // Counter is one bit wider than the address so the terminal value and
    // the post-increment value never alias onto each other.
    localparam logic [ADDR_W:0] c_cnt_last = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_cnt_one  = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0] val_q,   val_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (init_req) begin
                    val_d   = init_val;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = c_st_clear;
                end
            end
            c_st_clear: begin
                cnt_d = cnt_q + c_cnt_one;
                // Last write of the walk: drop busy and pulse done together
                // so busy falls exactly on entry to DONE.
                if (cnt_q == c_cnt_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = c_st_done;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy_q is high exactly while the FSM sits in CLEAR, so it doubles as
    // the write strobe.
    assign clr_en    = busy_q;
    assign clr_addr  = cnt_q[ADDR_W-1:0];
    assign clr_data  = val_q;
    assign busy      = busy_q;
    assign init_done = done_q;

endmodule
`default_nettype wire

// File: rtl/register_file_v3.sv
`default_nettype none
// ============================================================================
// Module      : register_file_v3
// Description : 2**ADDR_W x DATA_W register file with two registered read
//               ports, a CPU write port, a switch-driven record port and a
//               built-in clear engine. One array write per cycle with
//               priority clear engine > record > CPU.
// Ports       : clk, rst                  - clock, sync active-high reset
//               rd_addr1/2, rd_data1/2    - read ports, 1-cycle latency
//               wr_en, wr_addr, wr_data   - CPU write port
//               rec_en, rec_addr, rec_data - record (switch) write port
//               init_req, init_val        - clear engine start and fill value
//               busy, init_done           - clear engine status
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_v3
    import rf_pkg::*;
#(
    parameter int DATA_W = C_DEF_DATA_W,
    parameter int ADDR_W = C_DEF_ADDR_W,
    parameter int BYPASS = C_DEF_BYPASS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rec_en,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              init_req,
    input  logic [DATA_W-1:0] init_val,
    output logic              busy,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] w_rst_tbl [DEPTH];

    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;
    logic              w_busy;
    logic              w_init_done;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    rf_clear_engine #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_clear_engine (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_val  (init_val),
        .clr_en    (w_clr_en),
        .clr_addr  (w_clr_addr),
        .clr_data  (w_clr_data),
        .busy      (w_busy),
        .init_done (w_init_done)
    );

    // Constant reset table; folds away at elaboration.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rst_tbl[i] = DATA_W'(rf_reset_value(i, DATA_W));
        end
    end

    // Single write port into the array. The clear strobe equals busy, so
    // giving it top priority is what drops record/CPU writes during a fill.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_clr_en) begin
            w_we    = 1'b1;
            w_waddr = w_clr_addr;
            w_wdata = w_clr_data;
        end else if (rec_en) begin
            w_we    = 1'b1;
            w_waddr = rec_addr;
            w_wdata = rec_data;
        end else if (wr_en) begin
            w_we    = 1'b1;
            w_waddr = wr_addr;
            w_wdata = wr_data;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (w_we) begin
            regs_d[w_waddr] = w_wdata;
        end
    end

    // Read ports see the committed write of this edge only in write-first
    // mode; otherwise they return the array contents before the edge.
    always_comb begin
        rd_data1_d = regs_q[rd_addr1];
        rd_data2_d = regs_q[rd_addr2];
        if ((BYPASS != 0) && w_we && (w_waddr == rd_addr1)) begin
            rd_data1_d = w_wdata;
        end
        if ((BYPASS != 0) && w_we && (w_waddr == rd_addr2)) begin
            rd_data2_d = w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= w_rst_tbl[i];
            end
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign rd_data1  = rd_data1_q;
    assign rd_data2  = rd_data2_q;
    assign busy      = w_busy;
    assign init_done = w_init_done;

endmodule
`default_nettype wire

// File: tb/tb_register_file_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_v3
// Description : Self-checking bench for register_file_v3. Two instances share
//               all inputs: dut_b1 (write-first) and dut_b0 (read-first).
//               A plain array model tracks the register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_v3;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, rec_addr;
    logic [DATA_W-1:0] wr_data, rec_data, init_val;
    logic              wr_en, rec_en, init_req;

    logic [DATA_W-1:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic              busy_b1, done_b1, busy_b0, done_b0;

    int checks = 0;
    int errors = 0;
    int mem [DEPTH];

    register_file_v3 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_b1), .rd_data2(rd2_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rec_en(rec_en), .rec_addr(rec_addr), .rec_data(rec_data),
        .init_req(init_req), .init_val(init_val),
        .busy(busy_b1), .init_done(done_b1)
    );

    register_file_v3 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd1_b0), .rd_data2(rd2_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rec_en(rec_en), .rec_addr(rec_addr), .rec_data(rec_data),
        .init_req(init_req), .init_val(init_val),
        .busy(busy_b0), .init_done(done_b0)
    );

    function automatic int ref_reset(input int i);
        if (i == 0) return 6;
        if (i == 1) return 3;
        return i % 16;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rec_en = 1'b0; init_req = 1'b0;
        wr_addr = '0; wr_data = '0; rec_addr = '0; rec_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); init_val = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        step(); step();
        checks++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== 16'h0) begin
            errors++; $display("FAIL reset_rd got %h required 0000", {rd1_b1, rd2_b1, rd1_b0, rd2_b0});
        end
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0000) begin
            errors++; $display("FAIL reset_status got %b required 0000", {busy_b1, done_b1, busy_b0, done_b0});
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = ref_reset(i);
        rd_addr1 = 3'd0; rd_addr2 = 3'd1;
        step();
        checks++;
        if (rd1_b1 !== 4'd6 || rd2_b1 !== 4'd3 || rd1_b0 !== 4'd6 || rd2_b0 !== 4'd3) begin
            errors++; $display("FAIL reset_tbl01 got %0d %0d %0d %0d required 6 3 6 3", rd1_b1, rd2_b1, rd1_b0, rd2_b0);
        end
        rd_addr1 = 3'd7; rd_addr2 = 3'd2;
        step();
        checks++;
        if (rd1_b1 !== 4'd7 || rd2_b1 !== 4'd2 || rd1_b0 !== 4'd7 || rd2_b0 !== 4'd2) begin
            errors++; $display("FAIL reset_tbl72 got %0d %0d %0d %0d required 7 2 7 2", rd1_b1, rd2_b1, rd1_b0, rd2_b0);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd9; rd_addr1 = 3'd2; rd_addr2 = 3'd2;
        step();
        wr_en = 1'b0;
        checks++;
        if (rd1_b1 !== 4'd9 || rd2_b1 !== 4'd9) begin
            errors++; $display("FAIL bypass_wf got %0d %0d required 9 9", rd1_b1, rd2_b1);
        end
        checks++;
        if (rd1_b0 !== 4'd2 || rd2_b0 !== 4'd2) begin
            errors++; $display("FAIL bypass_rf got %0d %0d required 2 2", rd1_b0, rd2_b0);
        end
        mem[2] = 9;
        step();
        checks++;
        if (rd1_b0 !== 4'd9 || rd1_b1 !== 4'd9) begin
            errors++; $display("FAIL bypass_after got %0d %0d required 9 9", rd1_b1, rd1_b0);
        end
    endtask

    task automatic test_arbitration();
        // Same address: record wins.
        rec_en = 1'b1; rec_addr = 3'd4; rec_data = 4'd12;
        wr_en  = 1'b1; wr_addr  = 3'd4; wr_data  = 4'd1;
        rd_addr1 = 3'd4; rd_addr2 = 3'd4;
        step();
        checks++;
        if (rd1_b1 !== 4'd12 || rd1_b0 !== 4'(mem[4])) begin
            errors++; $display("FAIL arb_same got %0d %0d required 12 %0d", rd1_b1, rd1_b0, mem[4]);
        end
        mem[4] = 12;
        // Different addresses: only the record write happens.
        rec_addr = 3'd5; rec_data = 4'd11; wr_addr = 3'd6; wr_data = 4'd14;
        rd_addr1 = 3'd5; rd_addr2 = 3'd6;
        step();
        checks++;
        if (rd1_b1 !== 4'd11 || rd2_b1 !== 4'(mem[6]) || rd1_b0 !== 4'(mem[5]) || rd2_b0 !== 4'(mem[6])) begin
            errors++; $display("FAIL arb_diff got %0d %0d %0d %0d required 11 %0d %0d %0d",
                               rd1_b1, rd2_b1, rd1_b0, rd2_b0, mem[6], mem[5], mem[6]);
        end
        mem[5] = 11;
        idle_inputs();
        rd_addr1 = 3'd4; rd_addr2 = 3'd6;
        step();
        rd_addr1 = 3'd5;
        checks++;
        if (rd1_b1 !== 4'd12 || rd2_b1 !== 4'(mem[6]) || rd1_b0 !== 4'd12 || rd2_b0 !== 4'(mem[6])) begin
            errors++; $display("FAIL arb_readback got %0d %0d %0d %0d required 12 %0d", rd1_b1, rd2_b1, rd1_b0, rd2_b0, mem[6]);
        end
        step();
        checks++;
        if (rd1_b1 !== 4'd11 || rd1_b0 !== 4'd11) begin
            errors++; $display("FAIL arb_rec5 got %0d %0d required 11", rd1_b1, rd1_b0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int we, wa, wd, a1, a2, e1_wf, e2_wf, e1_rf, e2_rf;
            rd_addr1 = 3'($urandom_range(0, 7));
            rd_addr2 = 3'($urandom_range(0, 7));
            wr_en    = 1'($urandom_range(0, 1));
            rec_en   = 1'($urandom_range(0, 3) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            rec_addr = 3'($urandom_range(0, 7));
            wr_data  = 4'($urandom_range(0, 15));
            rec_data = 4'($urandom_range(0, 15));
            a1 = int'(rd_addr1); a2 = int'(rd_addr2);
            we = 0; wa = 0; wd = 0;
            if (rec_en) begin
                we = 1; wa = int'(rec_addr); wd = int'(rec_data);
            end else if (wr_en) begin
                we = 1; wa = int'(wr_addr); wd = int'(wr_data);
            end
            e1_rf = mem[a1]; e2_rf = mem[a2];
            e1_wf = (we == 1 && wa == a1) ? wd : mem[a1];
            e2_wf = (we == 1 && wa == a2) ? wd : mem[a2];
            if (we == 1) mem[wa] = wd;
            step();
            checks++;
            if (rd1_b1 !== 4'(e1_wf) || rd2_b1 !== 4'(e2_wf) || rd1_b0 !== 4'(e1_rf) || rd2_b0 !== 4'(e2_rf)) begin
                errors++; $display("FAIL random[%0d] got %0d %0d %0d %0d required %0d %0d %0d %0d", n,
                                   rd1_b1, rd2_b1, rd1_b0, rd2_b0, e1_wf, e2_wf, e1_rf, e2_rf);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        idle_inputs();
        init_val = 4'd10; init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b1010) begin
                errors++; $display("FAIL clear_busy[%0d] got %b required 1010", i, {busy_b1, done_b1, busy_b0, done_b0});
            end
            // Writes and a second request during busy must be dropped.
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'd5;
            rec_en = (i % 2 == 1); rec_addr = 3'(7 - i); rec_data = 4'd1;
            init_req = (i == 3); init_val = 4'd2;
            step();
        end
        idle_inputs();
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0101) begin
            errors++; $display("FAIL clear_done got %b required 0101", {busy_b1, done_b1, busy_b0, done_b0});
        end
        step();
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0000) begin
            errors++; $display("FAIL clear_pulse_end got %b required 0000", {busy_b1, done_b1, busy_b0, done_b0});
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 10;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = 3'(a); rd_addr2 = 3'(DEPTH - 1 - a);
            step();
            checks++;
            if (rd1_b1 !== 4'(mem[a]) || rd2_b1 !== 4'(mem[DEPTH-1-a]) || rd1_b0 !== 4'(mem[a]) || rd2_b0 !== 4'(mem[DEPTH-1-a])) begin
                errors++; $display("FAIL clear_fill[%0d] got %0d %0d %0d %0d required %0d %0d", a,
                                   rd1_b1, rd2_b1, rd1_b0, rd2_b0, mem[a], mem[DEPTH-1-a]);
            end
        end
    endtask

    task automatic test_restart_bypass();
        int pulses;
        idle_inputs();
        // init_req held high through CLEAR and DONE: only the IDLE cycle after
        // DONE may start the next run.
        init_val = 4'd7; init_req = 1'b1;
        step();
        pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (done_b1 === 1'b1) pulses++;
            checks++;
            if (busy_b1 !== 1'b1 || busy_b0 !== 1'b1) begin
                errors++; $display("FAIL restart_busy[%0d] got %b %b required 1 1", i, busy_b1, busy_b0);
            end
            if (i == 2) init_val = 4'd13;
            step();
        end
        checks++;
        if (pulses != 0 || {busy_b1, done_b1, busy_b0, done_b0} !== 4'b0101) begin
            errors++; $display("FAIL restart_done got %b early_pulses %0d required 0101 0", {busy_b1, done_b1, busy_b0, done_b0}, pulses);
        end
        step();
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0000) begin
            errors++; $display("FAIL restart_in_done got %b required 0000", {busy_b1, done_b1, busy_b0, done_b0});
        end
        step();
        init_req = 1'b0;
        checks++;
        if (busy_b1 !== 1'b1 || busy_b0 !== 1'b1) begin
            errors++; $display("FAIL restart_start got %b %b required 1 1", busy_b1, busy_b0);
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 7;
        step(); step(); step();
        // Engine writes address 3 on this edge.
        rd_addr1 = 3'd3; rd_addr2 = 3'd3;
        step();
        checks++;
        if (rd1_b1 !== 4'd13 || rd2_b1 !== 4'd13) begin
            errors++; $display("FAIL clear_bypass_wf got %0d %0d required 13 13", rd1_b1, rd2_b1);
        end
        checks++;
        if (rd1_b0 !== 4'(mem[3]) || rd2_b0 !== 4'(mem[3])) begin
            errors++; $display("FAIL clear_bypass_rf got %0d %0d required %0d", rd1_b0, rd2_b0, mem[3]);
        end
        step(); step(); step();
        checks++;
        if (busy_b1 !== 1'b1 || done_b1 !== 1'b0) begin
            errors++; $display("FAIL restart_last got %b %b required 1 0", busy_b1, done_b1);
        end
        step();
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0101) begin
            errors++; $display("FAIL restart_done2 got %b required 0101", {busy_b1, done_b1, busy_b0, done_b0});
        end
        step();
        for (int i = 0; i < DEPTH; i++) mem[i] = 13;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = 3'(a); rd_addr2 = 3'(DEPTH - 1 - a);
            step();
            checks++;
            if (rd1_b1 !== 4'(mem[a]) || rd2_b1 !== 4'(mem[DEPTH-1-a]) || rd1_b0 !== 4'(mem[a]) || rd2_b0 !== 4'(mem[DEPTH-1-a])) begin
                errors++; $display("FAIL restart_fill[%0d] got %0d %0d %0d %0d required %0d", a,
                                   rd1_b1, rd2_b1, rd1_b0, rd2_b0, mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int pulses;
        idle_inputs();
        init_val = 4'd15; init_req = 1'b1;
        step();
        init_req = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy_b1, done_b1, busy_b0, done_b0} !== 4'b0000) begin
            errors++; $display("FAIL midrst_status got %b required 0000", {busy_b1, done_b1, busy_b0, done_b0});
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = ref_reset(i);
        pulses = 0;
        for (int a = 0; a < DEPTH + 4; a++) begin
            rd_addr1 = 3'(a % DEPTH); rd_addr2 = 3'(DEPTH - 1 - (a % DEPTH));
            step();
            if (done_b1 !== 1'b0 || done_b0 !== 1'b0 || busy_b1 !== 1'b0) pulses++;
            checks++;
            if (rd1_b1 !== 4'(mem[a % DEPTH]) || rd2_b1 !== 4'(mem[DEPTH-1-(a % DEPTH)]) || rd1_b0 !== 4'(mem[a % DEPTH])) begin
                errors++; $display("FAIL midrst_tbl[%0d] got %0d %0d %0d required %0d %0d", a % DEPTH,
                                   rd1_b1, rd2_b1, rd1_b0, mem[a % DEPTH], mem[DEPTH-1-(a % DEPTH)]);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL midrst_no_pulse got %0d stray cycles required 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_arbitration();
        test_random();
        test_clear();
        test_restart_bypass();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
